// File: rtl/lsu_split.sv
// lsu_split: RV32I byte/half/word load-store unit in front of a word-wide synchronous BRAM port.
// Latency: resp_valid 1 cycle after accept, 2 cycles for a word-crossing access that gets split.
// Backpressure: req_ready only in IDLE, so one access is in flight at a time. LSU_SPLIT_MISALIGN_EN defined splits
// word-crossing accesses into two BRAM cycles; undefined, they are rejected with misalign_err and no memory write.
module lsu_split (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic [3:0]  mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        cross_q;
`ifdef LSU_SPLIT_MISALIGN_EN
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
`endif

  // Access size in bytes; unused codes fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Byte-lane mask of the access before it is shifted to its offset.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  logic [2:0]  req_end;
  logic        req_cross;
  logic        accept;
  logic [31:0] ld_raw;
  logic [31:0] ld_ext;

  // An access crosses into the next word when offset + size runs past byte 4.
  assign req_end   = {1'b0, req_addr[1:0]} + size_bytes(req_funct3);
  assign req_cross = (req_end > 3'd4);
  assign accept    = req_valid && req_ready;

  // Align the returned word(s) so the addressed byte lands in lane 0.
  always_comb begin
`ifdef LSU_SPLIT_MISALIGN_EN
    if (cross_q) begin
      ld_raw = 32'({mem_RD, lo_q} >> {off_q, 3'b000});
    end else begin
      ld_raw = mem_RD >> {off_q, 3'b000};
    end
`else
    ld_raw = mem_RD >> {off_q, 3'b000};
`endif
  end

  // Sign- or zero-extend the low n bytes according to funct3.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_ext = f3_q[2] ? {24'd0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = f3_q[2] ? {16'd0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // Next state and all outputs; rst suppresses handshakes and writes in the same cycle.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = 32'd0;
    misalign_err = 1'b0;
    mem_A        = 32'd0;
    mem_WD       = 32'd0;
    mem_WE       = 4'd0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        mem_A     = {req_addr[31:2], 2'b00};
        if (req_valid && !rst) begin
`ifdef LSU_SPLIT_MISALIGN_EN
          if (req_we) begin
            mem_WE = size_mask(req_funct3) << req_addr[1:0];
            mem_WD = req_wdata << {req_addr[1:0], 3'b000};
          end
          state_d = req_cross ? SECOND : RESP;
`else
          // A crossing access is refused outright: nothing is written.
          if (req_we && !req_cross) begin
            mem_WE = size_mask(req_funct3) << req_addr[1:0];
            mem_WD = req_wdata << {req_addr[1:0], 3'b000};
          end
          state_d = RESP;
`endif
        end
      end
      SECOND: begin
`ifdef LSU_SPLIT_MISALIGN_EN
        // Upper half of the shifted lane mask/data goes to the following word (wraps at 4 GiB).
        mem_A = {word_q + 30'd1, 2'b00};
        if (we_q && !rst) begin
          mem_WE = 4'(({4'd0, size_mask(f3_q)} << off_q) >> 4);
          mem_WD = 32'(({32'd0, wdata_q} << {off_q, 3'b000}) >> 32);
        end
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        resp_valid = !rst;
`ifdef LSU_SPLIT_MISALIGN_EN
        if (!rst && !we_q) begin
          resp_rdata = ld_ext;
        end
`else
        misalign_err = cross_q && !rst;
        if (!rst && !we_q && !cross_q) begin
          resp_rdata = ld_ext;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus request capture on accept and first-word capture in SECOND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      cross_q <= 1'b0;
`ifdef LSU_SPLIT_MISALIGN_EN
      word_q  <= 30'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= req_addr[1:0];
        f3_q    <= req_funct3;
        we_q    <= req_we;
        cross_q <= req_cross;
`ifdef LSU_SPLIT_MISALIGN_EN
        word_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
`endif
      end
`ifdef LSU_SPLIT_MISALIGN_EN
      if (state_q == SECOND) begin
        lo_q <= mem_RD;
      end
`endif
    end
  end

endmodule
